// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard / forwarding controller.
//   - forwarding-mux select codes
//   - result-source and pipeline-stage enums
//   - TUSE_NONE marker for operands that are never read
//   - tnew(): cycles until a producer's result exists, by stage and source
//   - sel_code(): youngest-first forwarding select from per-stage match bits
package hazard_pkg;

    localparam logic [2:0] SEL_RF    = 3'b000;  // register file / no forward
    localparam logic [2:0] SEL_AO_M  = 3'b001;  // ALU result sitting in M
    localparam logic [2:0] SEL_M4    = 3'b010;  // write-back data in W
    localparam logic [2:0] SEL_PC8_E = 3'b011;  // link address sitting in E
    localparam logic [2:0] SEL_PC8_M = 3'b100;  // link address sitting in M
    localparam logic [2:0] SEL_PC8_W = 3'b101;  // link address sitting in W

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC8 = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        STG_E = 2'd0,
        STG_M = 2'd1,
        STG_W = 2'd2
    } stage_t;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Cycles until the producer in stage stg has its result available.
    function automatic logic [1:0] tnew(input stage_t stg, input logic [1:0] src);
        logic [1:0] t;
        t = 2'd0;
        case (stg)
            STG_E: begin
                if (src == SRC_MEM)      t = 2'd2;
                else if (src == SRC_PC8) t = 2'd0;
                else                     t = 2'd1;
            end
            STG_M:   t = (src == SRC_MEM) ? 2'd1 : 2'd0;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    // The youngest matching stage decides even when its value is not ready
    // yet; in that case the stall logic holds the consumer and a later
    // cycle picks the value up from an older stage.
    function automatic logic [2:0] sel_code(
        input logic       hit_e,
        input logic [1:0] src_e,
        input logic       hit_m,
        input logic [1:0] src_m,
        input logic       hit_w,
        input logic [1:0] src_w
    );
        logic [2:0] code;
        code = SEL_RF;
        if (hit_e) begin
            code = (src_e == SRC_PC8) ? SEL_PC8_E : SEL_RF;
        end else if (hit_m) begin
            if (src_m == SRC_PC8)      code = SEL_PC8_M;
            else if (src_m == SRC_MEM) code = SEL_RF;
            else                       code = SEL_AO_M;
        end else if (hit_w) begin
            code = (src_w == SRC_PC8) ? SEL_PC8_W : SEL_M4;
        end
        return code;
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// hz_stage_reg: one entry of the controller's shadow pipeline.
//   clk        pipeline clock
//   reset_n    asynchronous active-low reset (entry becomes a bubble)
//   i_bubble   synchronous: load a bubble instead of the incoming entry
//   i_a3/o_a3  destination register (0 = no write)
//   i_src/o_src result source
//   i_rs/o_rs, i_rt/o_rt  consumer register fields
module hz_stage_reg #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_bubble,
    input  logic [AW-1:0] i_a3,
    input  logic [1:0]    i_src,
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rt,
    output logic [AW-1:0] o_a3,
    output logic [1:0]    o_src,
    output logic [AW-1:0] o_rs,
    output logic [AW-1:0] o_rt
);

    logic [AW-1:0] r_a3;
    logic [1:0]    r_src;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a3  <= '0;
            r_src <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
        end else if (i_bubble) begin
            r_a3  <= '0;
            r_src <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
        end else begin
            r_a3  <= i_a3;
            r_src <= i_src;
            r_rs  <= i_rs;
            r_rt  <= i_rt;
        end
    end

    assign o_a3  = r_a3;
    assign o_src = r_src;
    assign o_rs  = r_rs;
    assign o_rt  = r_rt;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall and forwarding-select generation for a 5-stage
// pipeline. Tracks producer/consumer info of the E, M and W instructions in
// its own shadow pipeline, so only D-stage decode fields come in.
//   clk, reset_n                pipeline clock, async active-low reset
//   rs_d, rt_d                  D-stage source registers
//   tuse_rs_d, tuse_rt_d        cycles until each operand is needed (3 = unused)
//   a3_d, src_d                 D-stage destination and result source
//   F_RS_sel, F_RT_sel          D-stage operand forward selects
//   F_ALUA_Esel, F_ALUB_Esel    E-stage ALU operand forward selects
//   F_WD_Msel                   M-stage store-data forward select
//   stall, bubble_e             freeze PC/FD, clear D/E
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int AW = 5,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic [1:0]    tuse_rs_d,
    input  logic [1:0]    tuse_rt_d,
    input  logic [AW-1:0] a3_d,
    input  logic [1:0]    src_d,
    output logic [SW-1:0] F_RS_sel,
    output logic [SW-1:0] F_RT_sel,
    output logic [SW-1:0] F_ALUA_Esel,
    output logic [SW-1:0] F_ALUB_Esel,
    output logic [SW-1:0] F_WD_Msel,
    output logic          stall,
    output logic          bubble_e
);

    // Index 0 is the incoming D instruction, 1..3 are the E, M, W entries.
    logic [AW-1:0] w_a3  [0:3];
    logic [1:0]    w_src [0:3];
    logic [AW-1:0] w_rs  [0:3];
    logic [AW-1:0] w_rt  [0:3];
    logic          w_stall;
    logic          w_stall_rs;
    logic          w_stall_rt;
    logic          w_unused;

    // $0 is hard-wired, so a write to it never produces anything to forward.
    function automatic logic hit(input logic [AW-1:0] a3, input logic [AW-1:0] r);
        return (a3 == r) && (r != '0);
    endfunction

    assign w_a3[0]  = a3_d;
    // The undefined source code 3 behaves like an ALU result.
    assign w_src[0] = (src_d == 2'd3) ? 2'(SRC_ALU) : src_d;
    assign w_rs[0]  = rs_d;
    assign w_rt[0]  = rt_d;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            hz_stage_reg #(.AW(AW)) u_reg (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_bubble ((gi == 0) ? w_stall : 1'b0),
                .i_a3     (w_a3[gi]),
                .i_src    (w_src[gi]),
                .i_rs     (w_rs[gi]),
                .i_rt     (w_rt[gi]),
                .o_a3     (w_a3[gi+1]),
                .o_src    (w_src[gi+1]),
                .o_rs     (w_rs[gi+1]),
                .o_rt     (w_rt[gi+1])
            );
        end
    endgenerate

    // A consumer stalls when any E or M producer of its register will not
    // have the value by the time the consumer needs it. W is always ready.
    always_comb begin
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        if (tuse_rs_d != TUSE_NONE) begin
            w_stall_rs = (hit(w_a3[1], rs_d) && (tuse_rs_d < tnew(STG_E, w_src[1])))
                      || (hit(w_a3[2], rs_d) && (tuse_rs_d < tnew(STG_M, w_src[2])));
        end
        if (tuse_rt_d != TUSE_NONE) begin
            w_stall_rt = (hit(w_a3[1], rt_d) && (tuse_rt_d < tnew(STG_E, w_src[1])))
                      || (hit(w_a3[2], rt_d) && (tuse_rt_d < tnew(STG_M, w_src[2])));
        end
        w_stall = w_stall_rs || w_stall_rt;
    end

    assign stall    = w_stall;
    assign bubble_e = w_stall;

    assign F_RS_sel = SW'(sel_code(hit(w_a3[1], rs_d), w_src[1],
                                   hit(w_a3[2], rs_d), w_src[2],
                                   hit(w_a3[3], rs_d), w_src[3]));
    assign F_RT_sel = SW'(sel_code(hit(w_a3[1], rt_d), w_src[1],
                                   hit(w_a3[2], rt_d), w_src[2],
                                   hit(w_a3[3], rt_d), w_src[3]));

    // E-stage consumers only see producers that are older than E.
    assign F_ALUA_Esel = SW'(sel_code(1'b0, w_src[1],
                                      hit(w_a3[2], w_rs[1]), w_src[2],
                                      hit(w_a3[3], w_rs[1]), w_src[3]));
    assign F_ALUB_Esel = SW'(sel_code(1'b0, w_src[1],
                                      hit(w_a3[2], w_rt[1]), w_src[2],
                                      hit(w_a3[3], w_rt[1]), w_src[3]));

    // Store data in M can only come from W.
    assign F_WD_Msel = SW'(sel_code(1'b0, w_src[1],
                                    1'b0, w_src[2],
                                    hit(w_a3[3], w_rt[2]), w_src[3]));

    // Consumer fields of older entries are carried along but not consulted.
    assign w_unused = ^{w_rs[2], w_rs[3], w_rt[3]};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] rs_d = '0;
    logic [AW-1:0] rt_d = '0;
    logic [1:0]    tuse_rs_d = 2'd3;
    logic [1:0]    tuse_rt_d = 2'd3;
    logic [AW-1:0] a3_d = '0;
    logic [1:0]    src_d = '0;
    logic [SW-1:0] F_RS_sel;
    logic [SW-1:0] F_RT_sel;
    logic [SW-1:0] F_ALUA_Esel;
    logic [SW-1:0] F_ALUB_Esel;
    logic [SW-1:0] F_WD_Msel;
    logic          stall;
    logic          bubble_e;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.AW(AW), .SW(SW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .tuse_rs_d   (tuse_rs_d),
        .tuse_rt_d   (tuse_rt_d),
        .a3_d        (a3_d),
        .src_d       (src_d),
        .F_RS_sel    (F_RS_sel),
        .F_RT_sel    (F_RT_sel),
        .F_ALUA_Esel (F_ALUA_Esel),
        .F_ALUB_Esel (F_ALUB_Esel),
        .F_WD_Msel   (F_WD_Msel),
        .stall       (stall),
        .bubble_e    (bubble_e)
    );

    // ---------------- reference model ----------------
    // History of issued instructions indexed by age: 1 = E, 2 = M, 3 = W.
    int h_a3  [1:3];
    int h_src [1:3];
    int h_rs  [1:3];
    int h_rt  [1:3];

    // Age at which a producer's result first exists in a pipeline register:
    // link address after D (age 1), ALU after E (age 2), load after M (age 3).
    function automatic int ready_age(input int src);
        if (src == 1) return 3;
        if (src == 2) return 1;
        return 2;
    endfunction

    function automatic int tnew_m(input int age, input int src);
        int t;
        t = ready_age(src) - age;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int code_m(input int age, input int src);
        if (age == 1) return (src == 2) ? 3 : 0;
        if (age == 2) return (src == 2) ? 4 : ((src == 1) ? 0 : 1);
        return (src == 2) ? 5 : 2;
    endfunction

    // Forward select for a consumer at cons_age reading register r.
    function automatic int sel_m(input int r, input int cons_age);
        if (r == 0) return 0;
        for (int k = cons_age + 1; k <= 3; k++)
            if (h_a3[k] == r) return code_m(k, h_src[k]);
        return 0;
    endfunction

    function automatic bit stall_one(input int r, input int tuse);
        if (tuse == 3 || r == 0) return 1'b0;
        for (int k = 1; k <= 2; k++)
            if (h_a3[k] == r && tuse < tnew_m(k, h_src[k])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        return stall_one(int'(rs_d), int'(tuse_rs_d)) || stall_one(int'(rt_d), int'(tuse_rt_d));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= 3; k++) begin
                h_a3[k]  <= 0;
                h_src[k] <= 0;
                h_rs[k]  <= 0;
                h_rt[k]  <= 0;
            end
        end else begin
            for (int k = 3; k >= 2; k--) begin
                h_a3[k]  <= h_a3[k-1];
                h_src[k] <= h_src[k-1];
                h_rs[k]  <= h_rs[k-1];
                h_rt[k]  <= h_rt[k-1];
            end
            if (model_stall()) begin
                h_a3[1]  <= 0;
                h_src[1] <= 0;
                h_rs[1]  <= 0;
                h_rt[1]  <= 0;
            end else begin
                h_a3[1]  <= int'(a3_d);
                h_src[1] <= (src_d == 2'd3) ? 0 : int'(src_d);
                h_rs[1]  <= int'(rs_d);
                h_rt[1]  <= int'(rt_d);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (cmp_en && reset_n) begin
            chk("m_stall",    int'(stall),       int'(model_stall()));
            chk("m_bubble_e", int'(bubble_e),    int'(model_stall()));
            chk("m_F_RS_sel", int'(F_RS_sel),    sel_m(int'(rs_d), 0));
            chk("m_F_RT_sel", int'(F_RT_sel),    sel_m(int'(rt_d), 0));
            chk("m_F_ALUA",   int'(F_ALUA_Esel), sel_m(h_rs[1], 1));
            chk("m_F_ALUB",   int'(F_ALUB_Esel), sel_m(h_rt[1], 1));
            chk("m_F_WD",     int'(F_WD_Msel),   sel_m(h_rt[2], 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input string tag, input int rs, input int rt, input int tr,
                         input int tt, input int a3, input int src);
        @(negedge clk);
        rs_d      = AW'(rs);
        rt_d      = AW'(rt);
        tuse_rs_d = 2'(tr);
        tuse_rt_d = 2'(tt);
        a3_d      = AW'(a3);
        src_d     = 2'(src);
        #2;
        $display("txn %-6s rs=%0d rt=%0d tuse=%0d/%0d a3=%0d src=%0d | stall=%0d rs=%0d rt=%0d A=%0d B=%0d WD=%0d",
                 tag, rs, rt, tr, tt, a3, src, stall, F_RS_sel, F_RT_sel,
                 F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel);
    endtask

    task automatic nop();
        issue("nop", 0, 0, 3, 3, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        rs_d      = '0;
        rt_d      = '0;
        tuse_rs_d = 2'd3;
        tuse_rt_d = 2'd3;
        a3_d      = '0;
        src_d     = '0;
        #2;
        chk("rst_stall", int'(stall), 0);
        chk("rst_sels", int'({F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel}), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;

        // reset state after release
        nop();
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_bubble", int'(bubble_e), 0);
        chk("post_rst_sels", int'({F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel}), 0);

        // load-use into a branch: two stall cycles then W forward
        issue("lw8", 0, 0, 3, 3, 8, 1);
        issue("beq", 8, 0, 0, 3, 0, 0);
        chk("lw_beq_c1_stall", int'(stall), 1);
        chk("lw_beq_c1_bubble", int'(bubble_e), 1);
        issue("beq", 8, 0, 0, 3, 0, 0);
        chk("lw_beq_c2_stall", int'(stall), 1);
        issue("beq", 8, 0, 0, 3, 0, 0);
        chk("lw_beq_c3_stall", int'(stall), 0);
        chk("lw_beq_c3_rs", int'(F_RS_sel), 2);

        // reset while stalled drops the stall at once
        do_reset();
        issue("lw8", 0, 0, 3, 3, 8, 1);
        issue("beq", 8, 0, 0, 3, 0, 0);
        chk("pre_rst_stall", int'(stall), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_rs", int'(F_RS_sel), 0);
        @(negedge clk);
        reset_n = 1'b1;
        issue("beq", 8, 0, 0, 3, 0, 0);
        chk("after_rst_stall", int'(stall), 0);
        chk("after_rst_rs", int'(F_RS_sel), 0);

        // ALU to ALU: M forward, then W forward with a gap
        do_reset();
        issue("addu9", 1, 2, 1, 1, 9, 0);
        issue("addu", 9, 3, 1, 1, 10, 0);
        chk("alu_alu_stall", int'(stall), 0);
        nop();
        chk("alu_alu_A_M", int'(F_ALUA_Esel), 1);
        issue("addu9", 1, 2, 1, 1, 9, 0);
        nop();
        issue("addu", 9, 3, 1, 1, 10, 0);
        nop();
        chk("alu_alu_A_W", int'(F_ALUA_Esel), 2);

        // jal then jr $31
        do_reset();
        issue("jal", 0, 0, 3, 3, 31, 2);
        issue("jr", 31, 0, 0, 3, 0, 0);
        chk("jal_jr_stall", int'(stall), 0);
        chk("jal_jr_rs_E", int'(F_RS_sel), 3);
        issue("jal", 0, 0, 3, 3, 31, 2);
        nop();
        issue("jr", 31, 0, 0, 3, 0, 0);
        chk("jal_jr_rs_M", int'(F_RS_sel), 4);

        // load then store of the loaded value
        do_reset();
        issue("lw10", 0, 0, 3, 3, 10, 1);
        issue("sw", 0, 10, 1, 2, 0, 0);
        chk("lw_sw_stall", int'(stall), 0);
        nop();
        chk("lw_sw_B_memM", int'(F_ALUB_Esel), 0);
        nop();
        chk("lw_sw_WD", int'(F_WD_Msel), 2);

        // writers of $0 never forward or stall
        do_reset();
        issue("w0a", 0, 0, 3, 3, 0, 0);
        issue("w0m", 0, 0, 3, 3, 0, 1);
        issue("w0p", 0, 0, 3, 3, 0, 2);
        issue("use0", 0, 0, 0, 0, 0, 0);
        chk("zero_stall", int'(stall), 0);
        chk("zero_sels", int'({F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel}), 0);

        // same register written in E and M: E wins on both paths
        do_reset();
        issue("w5alu", 0, 0, 3, 3, 5, 0);
        issue("w5pc8", 0, 0, 3, 3, 5, 2);
        issue("use5", 5, 5, 1, 1, 0, 0);
        chk("eprio_stall", int'(stall), 0);
        chk("eprio_rs", int'(F_RS_sel), 3);
        chk("eprio_rt", int'(F_RT_sel), 3);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            if (stall && ($urandom_range(0, 3) != 0)) begin
                issue("hold", int'(rs_d), int'(rt_d), int'(tuse_rs_d), int'(tuse_rt_d),
                      int'(a3_d), int'(src_d));
            end else begin
                issue("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
